// File: rtl/and_tree_pipe_if.sv
// Stream bundle for and_tree_pipe: per-segment match beats in, entry-match result out.
interface and_tree_pipe_if #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned SEG_NUM = 12,
  parameter int unsigned IDX_W   = $clog2(DEPTH)
);
  logic                       s_valid;
  logic                       s_ready;
  logic [SEG_NUM*DEPTH-1:0]   s_match;
  logic [SEG_NUM-1:0]         s_seg_en;
  logic                       m_valid;
  logic                       m_ready;
  logic [DEPTH-1:0]           m_match;
  logic                       m_hit;
  logic [IDX_W-1:0]           m_idx;

  modport master (
    output s_valid, s_match, s_seg_en, m_ready,
    input  s_ready, m_valid, m_match, m_hit, m_idx
  );

  modport slave (
    input  s_valid, s_match, s_seg_en, m_ready,
    output s_ready, m_valid, m_match, m_hit, m_idx
  );
endinterface

// File: rtl/and_tree_pipe.sv
// Pipelined AND-reduction of SEG_NUM masked match vectors with a registered
// lowest-index priority encoder and valid/ready flow control.
module and_tree_pipe #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned SEG_NUM = 12,
  parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  and_tree_pipe_if.slave bus
);
  localparam int unsigned NG = (SEG_NUM + 5) / 6;
  localparam int unsigned L  = (NG > 1) ? 2 : 1;
  localparam int unsigned NS = L + 1;

  if (DEPTH % 4 != 0) begin : g_chk_depth
    $error("and_tree_pipe: DEPTH must be a multiple of 4");
  end
  if (SEG_NUM < 1 || SEG_NUM > 36) begin : g_chk_seg
    $error("and_tree_pipe: SEG_NUM must be in 1..36");
  end

  logic [NS-1:0] v_q, v_d, adv, load;

  // A stage advances iff it is valid and some later stage is empty or the
  // sink is ready; unrolled this way to avoid a bit-to-bit ripple in one vector.
  always_comb begin
    logic room;
    room = bus.m_ready;
    adv  = '0;
    load = '0;
    for (int unsigned j = 0; j < NS; j++) begin
      adv[NS-1-j] = v_q[NS-1-j] & room;
      room        = room | ~v_q[NS-1-j];
    end
    load[0] = bus.s_valid & (~v_q[0] | adv[0]);
    for (int unsigned i = 1; i < NS; i++) begin
      load[i] = adv[i-1];
    end
    v_d = (v_q & ~adv) | load;
  end

  assign bus.s_ready = ~v_q[0] | adv[0];
  assign bus.m_valid = v_q[NS-1];

  logic [DEPTH-1:0] seg_m [NG*6];
  logic [DEPTH-1:0] l1_d  [NG];
  logic [DEPTH-1:0] l1_q  [NG];

  always_comb begin
    for (int unsigned k = 0; k < NG*6; k++) begin
      seg_m[k] = '1;
    end
    for (int unsigned k = 0; k < SEG_NUM; k++) begin
      seg_m[k] = bus.s_match[k*DEPTH +: DEPTH] | {DEPTH{~bus.s_seg_en[k]}};
    end
    for (int unsigned g = 0; g < NG; g++) begin
      l1_d[g] = '0;
      for (int unsigned q = 0; q < DEPTH/4; q++) begin
        l1_d[g][q*4 +: 4] = seg_m[g*6][q*4 +: 4]   & seg_m[g*6+1][q*4 +: 4] &
                            seg_m[g*6+2][q*4 +: 4] & seg_m[g*6+3][q*4 +: 4] &
                            seg_m[g*6+4][q*4 +: 4] & seg_m[g*6+5][q*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned g = 0; g < NG; g++) begin
        l1_q[g] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (load[0]) begin
        for (int unsigned g = 0; g < NG; g++) begin
          l1_q[g] <= l1_d[g];
        end
      end
    end
  end

  logic [DEPTH-1:0] last_lvl;

  if (L == 2) begin : g_lvl2
    logic [DEPTH-1:0] l2_d, l2_q;

    always_comb begin
      l2_d = '1;
      for (int unsigned g = 0; g < NG; g++) begin
        l2_d = l2_d & l1_q[g];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        l2_q <= '0;
      end else if (load[1]) begin
        l2_q <= l2_d;
      end
    end

    assign last_lvl = l2_q;
  end else begin : g_lvl1
    assign last_lvl = l1_q[0];
  end

  logic             hit_d;
  logic [IDX_W-1:0] idx_d;
  logic [DEPTH-1:0] match_q;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;

  always_comb begin
    hit_d = |last_lvl;
    idx_d = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (last_lvl[DEPTH-1-j]) begin
        idx_d = IDX_W'(DEPTH - 1 - j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else if (load[NS-1]) begin
      match_q <= last_lvl;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.m_match = match_q;
  assign bus.m_hit   = hit_q;
  assign bus.m_idx   = idx_q;
endmodule

// File: tb/tb_and_tree_pipe.sv
// Scoreboard bench for and_tree_pipe across several SEG_NUM/DEPTH configurations.
module tb_and_tree_pipe;
  localparam int NI = 5;
  localparam int SN_C [NI] = '{12, 1, 6, 7, 36};
  localparam int DP_C [NI] = '{64, 4, 64, 4, 64};

  typedef struct {
    logic [63:0] match;
    logic        hit;
    logic [5:0]  idx;
    int          cyc;
    bit          lat_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_ready = 1'b1;

  logic        s_valid [NI];
  logic [63:0] segv    [NI][36];
  logic [35:0] env     [NI];
  logic        s_ready [NI];
  logic        m_valid [NI];
  logic        m_hit   [NI];
  logic [63:0] m_match [NI];
  logic [5:0]  m_idx   [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : u
    localparam int S = SN_C[gi];
    localparam int D = DP_C[gi];
    and_tree_pipe_if #(.DEPTH(D), .SEG_NUM(S)) bus ();
    and_tree_pipe #(.DEPTH(D), .SEG_NUM(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign bus.s_valid  = s_valid[gi];
    assign bus.s_seg_en = env[gi][S-1:0];
    assign bus.m_ready  = m_ready;
    for (genvar k = 0; k < S; k++) begin : seg
      assign bus.s_match[k*D +: D] = segv[gi][k][D-1:0];
    end
    assign s_ready[gi] = bus.s_ready;
    assign m_valid[gi] = bus.m_valid;
    assign m_hit[gi]   = bus.m_hit;
    assign m_match[gi] = 64'(bus.m_match);
    assign m_idx[gi]   = 6'(bus.m_idx);
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          got    [NI];
  bit          lat_mode = 1'b0;
  bit          done     = 1'b0;
  exp_t        expq   [NI][$];
  bit          hold   [NI];
  logic [63:0] pm     [NI];
  logic        ph     [NI];
  logic [5:0]  pidx   [NI];
  logic [63:0] res_m  [NI];
  logic        res_h  [NI];
  logic [5:0]  res_i  [NI];
  logic [63:0] dv     [36];
  logic [35:0] den;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: AND of enabled segments over DEPTH bits, then lowest set bit.
  function automatic exp_t model(input int g);
    exp_t        e;
    logic [63:0] m;
    bit          found;
    m = '1;
    m = m >> (64 - DP_C[g]);
    for (int k = 0; k < SN_C[g]; k++)
      if (env[g][k]) m = m & segv[g][k];
    e.match = m;
    e.hit   = (m != 64'd0);
    e.idx   = 6'd0;
    found   = 1'b0;
    for (int i = 0; i < DP_C[g]; i++)
      if (!found && m[i]) begin
        e.idx = 6'(i);
        found = 1'b1;
      end
    e.cyc     = cyc;
    e.lat_chk = lat_mode;
    return e;
  endfunction

  task automatic new_beat(input int g, input bit dir);
    if (dir) begin
      for (int k = 0; k < 36; k++) segv[g][k] = dv[k];
      env[g] = den;
    end else begin
      for (int k = 0; k < 36; k++)
        segv[g][k] = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      case ($urandom_range(0, 5))
        0:       env[g] = '1;
        1:       env[g] = '0;
        default: env[g] = 36'({$urandom, $urandom});
      endcase
    end
  endtask

  // stall > 0: m_ready low for the first 'stall' edges; stall < 0: random m_ready.
  task automatic stream(input int n, input int stall, input bit dir);
    int left   [NI];
    bit fire   [NI];
    int acc_st [NI];
    bit busy;
    lat_mode = (stall == 0);
    if (stall < 0) m_ready = 1'($urandom_range(0, 1));
    else           m_ready = (stall == 0);
    for (int g = 0; g < NI; g++) begin
      left[g]   = n;
      acc_st[g] = 0;
      new_beat(g, dir);
      s_valid[g] = 1'b1;
    end
    busy = 1'b1;
    for (int t = 0; t < 5000 && busy; t++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        fire[g] = s_valid[g] && s_ready[g];
        if (!m_ready && fire[g]) acc_st[g]++;
        if (stall == 0 && s_valid[g])
          chk($sformatf("inst%0d s_ready while streaming", g), 64'(s_ready[g]), 64'd1);
        if (stall > 0 && t == stall - 1)
          chk($sformatf("inst%0d s_ready when full", g), 64'(s_ready[g]), 64'd0);
      end
      @(posedge clk); #1;
      busy = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (fire[g]) begin
          left[g]--;
          if (left[g] > 0) new_beat(g, dir);
          else             s_valid[g] = 1'b0;
        end
        if (s_valid[g]) busy = 1'b1;
      end
      if (stall < 0) m_ready = 1'($urandom_range(0, 1));
      else           m_ready = (t + 1 >= stall);
    end
    chk("stream timeout", 64'(busy), 64'd0);
    for (int g = 0; g < NI; g++) s_valid[g] = 1'b0;
    if (stall > 0)
      for (int g = 0; g < NI; g++)
        chk($sformatf("inst%0d beats accepted under stall", g), 64'(acc_st[g]),
            64'((SN_C[g] <= 6) ? 2 : 3));
  endtask

  task automatic drain();
    int pending;
    m_ready = 1'b1;
    pending = 1;
    for (int t = 0; t < 200 && pending != 0; t++) begin
      @(negedge clk);
      pending = 0;
      for (int g = 0; g < NI; g++) pending += expq[g].size();
    end
    chk("drain pending beats", 64'(pending), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s inst%0d m_valid", tag, g), 64'(m_valid[g]), 64'd0);
      chk($sformatf("%s inst%0d m_match", tag, g), m_match[g], 64'd0);
      chk($sformatf("%s inst%0d m_hit", tag, g), 64'(m_hit[g]), 64'd0);
      chk($sformatf("%s inst%0d m_idx", tag, g), 64'(m_idx[g]), 64'd0);
      chk($sformatf("%s inst%0d s_ready", tag, g), 64'(s_ready[g]), 64'd1);
    end
  endtask

  task automatic check_res0(input string tag, input logic [63:0] m, input logic h, input logic [5:0] i);
    chk({tag, " m_match"}, res_m[0], m);
    chk({tag, " m_hit"}, 64'(res_h[0]), 64'(h));
    chk({tag, " m_idx"}, 64'(res_i[0]), 64'(i));
  endtask

  initial begin
    int g0 [NI];
    for (int g = 0; g < NI; g++) begin
      s_valid[g] = 1'b0;
      env[g]     = '1;
      got[g]     = 0;
      hold[g]    = 1'b0;
      for (int k = 0; k < 36; k++) segv[g][k] = '1;
    end
    fork
      begin : monitor
        exp_t e;
        while (!done) begin
          @(negedge clk);
          cyc++;
          for (int g = 0; g < NI; g++) begin
            if (rst) begin
              expq[g].delete();
              hold[g] = 1'b0;
            end else begin
              if (hold[g]) begin
                chk($sformatf("inst%0d held m_valid", g), 64'(m_valid[g]), 64'd1);
                chk($sformatf("inst%0d held m_match", g), m_match[g], pm[g]);
                chk($sformatf("inst%0d held m_hit", g), 64'(m_hit[g]), 64'(ph[g]));
                chk($sformatf("inst%0d held m_idx", g), 64'(m_idx[g]), 64'(pidx[g]));
              end
              if (m_valid[g] && m_ready) begin
                if (expq[g].size() == 0) begin
                  chk($sformatf("inst%0d unexpected m_valid", g), 64'(m_valid[g]), 64'd0);
                end else begin
                  e = expq[g].pop_front();
                  chk($sformatf("inst%0d m_match", g), m_match[g], e.match);
                  chk($sformatf("inst%0d m_hit", g), 64'(m_hit[g]), 64'(e.hit));
                  chk($sformatf("inst%0d m_idx", g), 64'(m_idx[g]), 64'(e.idx));
                  if (e.lat_chk)
                    chk($sformatf("inst%0d latency", g), 64'(cyc - e.cyc),
                        64'((SN_C[g] <= 6) ? 2 : 3));
                end
                got[g]++;
                res_m[g] = m_match[g];
                res_h[g] = m_hit[g];
                res_i[g] = m_idx[g];
              end
              hold[g] = m_valid[g] && !m_ready;
              pm[g]   = m_match[g];
              ph[g]   = m_hit[g];
              pidx[g] = m_idx[g];
              if (s_valid[g] && s_ready[g]) expq[g].push_back(model(g));
            end
          end
        end
      end
      begin : stimulus
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");
        @(posedge clk); #1;

        for (int k = 0; k < 36; k++) dv[k] = '1;
        dv[0] = 64'h00F0;
        dv[1] = 64'h0FF0;
        den   = '1;
        stream(1, 0, 1'b1);
        drain();
        check_res0("single beat", 64'h00F0, 1'b1, 6'd4);

        for (int k = 0; k < 36; k++) dv[k] = '1;
        dv[3] = 64'h1;
        dv[9] = 64'h2;
        stream(1, 0, 1'b1);
        drain();
        check_res0("disjoint", 64'h0, 1'b0, 6'd0);
        den[9] = 1'b0;
        stream(1, 0, 1'b1);
        drain();
        check_res0("seg9 masked", 64'h1, 1'b1, 6'd0);
        den = '0;
        stream(1, 0, 1'b1);
        drain();
        check_res0("all masked", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd0);

        for (int g = 0; g < NI; g++) g0[g] = got[g];
        stream(20, 0, 1'b0);
        drain();
        for (int g = 0; g < NI; g++)
          chk($sformatf("inst%0d streamed results", g), 64'(got[g] - g0[g]), 64'd20);

        for (int g = 0; g < NI; g++) g0[g] = got[g];
        stream(12, 5, 1'b0);
        drain();
        for (int g = 0; g < NI; g++)
          chk($sformatf("inst%0d backpressure results", g), 64'(got[g] - g0[g]), 64'd12);

        stream(2, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid-flight reset");
        repeat (10) @(posedge clk);
        #1;

        stream(300, 0, 1'b0);
        drain();
        stream(300, -1, 1'b0);
        drain();
        done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/and_tree_pipe.md
Name: and_tree_pipe

Overview:
- Pipelined, parametrised AND-reduction tree for fractcam match vectors.
- Combines SEG_NUM per-segment match vectors, each DEPTH bits wide, into one DEPTH-bit entry-match vector.
- Appends a lowest-index priority encoder to the result.
- Sits between the per-segment LUT-RAM match arrays and the CAM lookup result interface. Generalises the fixed 6-input combinational AND stage: any segment count, runtime segment enable mask, registered levels, valid/ready flow control.

Parameters:
- DEPTH, 64, number of CAM entries. Must be a multiple of 4; elaboration error otherwise.
- SEG_NUM, 12, number of match vectors to AND. Range 1..36; elaboration error otherwise.
- IDX_W, $clog2(DEPTH), width of the match index output.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- s_valid, input, 1, input beat valid.
- s_ready, output, 1, input beat accepted when s_valid && s_ready.
- s_match, input, SEG_NUM*DEPTH, segment vectors. Segment k occupies bits [k*DEPTH +: DEPTH].
- s_seg_en, input, SEG_NUM, per-segment enable. A disabled segment is forced to all-ones.
- m_valid, output, 1, result valid.
- m_ready, input, 1, result accepted when m_valid && m_ready.
- m_match, output, DEPTH, AND of all enabled segments.
- m_hit, output, 1, m_match != 0.
- m_idx, output, IDX_W, index of the lowest set bit of m_match. 0 when m_hit = 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Tree levels: L = number of 6-input levels needed to reduce SEG_NUM to 1, minimum 1.
  - SEG_NUM 1..6 gives L = 1; 7..36 gives L = 2.
  - Level 1 groups segments 6 at a time (last group padded with ones). Level 2 ANDs the level-1 group results.
  - Each level is registered. Every group AND is a 6-input AND per entry bit, realised per 4 entries as one LUT6 slice.
- Masking is applied before level 1: seg_k = s_match[k] | {DEPTH{~s_seg_en[k]}}.
  - All segments disabled gives an all-ones m_match, m_hit = 1, m_idx = 0.
- Encoder stage: one registered stage after the last level computes m_hit and m_idx from the level-L result; m_match is passed through.
- Latency: L+1 cycles from input accept to m_valid, with no backpressure. Default parameters give latency 3.
- Throughput: one beat per cycle while m_ready = 1.
- Flow control: stage i holds valid_i and data_i.
  - Stage i loads when its predecessor is valid and (!valid_i || stage i advances).
  - The last stage advances on m_ready.
  - s_ready = !valid_0 || stage 0 advances. This is combinational from m_ready through the valid chain; no bubble is inserted under backpressure.
- Backpressure:
  - When m_ready = 0 with all stages full, s_ready = 0. m_match, m_hit and m_idx stay stable while m_valid = 1 and m_ready = 0.
  - Beats are never dropped, duplicated or reordered.
- Simultaneous events: a load and a drain of the same stage in one cycle is a pass-through; the stage stays valid with new data.
- Reset:
  - All valid bits are 0, so m_valid = 0.
  - m_match = 0, m_hit = 0, m_idx = 0.
  - s_ready reads 1 in the cycle after rst deasserts.
  - Asserting rst mid-operation discards all in-flight beats. No output handshake occurs for them.
- Data registers clear on reset only. Their contents are don't-care while their stage is invalid, but outputs must read 0 until the first valid result.

Test Plan:
- Default params, reset then one beat: segment 0 = 0x00F0, segment 1 = 0x0FF0, all other segments all-ones, s_seg_en = all ones, m_ready = 1.
  - Required: m_valid exactly 3 cycles after accept, m_match = 0x00F0, m_hit = 1, m_idx = 4.
- Disjoint segments: segment 3 = 0x1, segment 9 = 0x2 (all others all-ones), all segments enabled.
  - Required: m_match = 0, m_hit = 0, m_idx = 0.
  - Repeat with s_seg_en[9] = 0. Required: m_match = 0x1, m_idx = 0.
- Streaming: 20 back-to-back beats with m_ready = 1.
  - Required: s_ready always 1, 20 results in order, first result at cycle 3, one result per cycle after that.
- Backpressure: stream beats while holding m_ready = 0 for 5 cycles.
  - Required: exactly 3 beats accepted, then s_ready = 0.
  - Required: output held stable throughout.
  - Required: after release, every beat is delivered in order with no loss.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle.
  - Required: m_valid = 0 and outputs = 0 the next cycle; no stale result ever appears.
- Parameter sweep: SEG_NUM in {1, 6, 7, 36} and DEPTH in {4, 64}, random vectors and masks against a behavioural model.
  - Required: latency is 2 for SEG_NUM ≤ 6 and 3 otherwise; every result matches the model.
